// File: rtl/rom_arb_pkg.sv
// Shared types, defaults and the round-robin pick function for the ROM arbiter.
package rom_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int MAX_REQ     = 8;

  typedef enum logic {
    IDLE,
    RESP
  } rom_arb_state_e;

  // Walks the requesters starting at ptr and wrapping modulo n.
  // The first valid requester found gets the one-hot grant.
  function automatic logic [MAX_REQ-1:0] onehot_rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] pick;
    logic [2:0]         pos;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = 3'((int'(ptr) + k) % n);
      if ((k < n) && !found && valid[pos]) begin
        pick[pos] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the one-hot grant, its index and a flag.
module rr_picker
  import rom_arb_pkg::*;
#(
  parameter int N     = NUM_REQ_DEF,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    valid_ext        = '0;
    valid_ext[N-1:0] = valid;
    pick             = onehot_rr_pick(valid_ext, 3'(ptr), N);
    grant            = pick[N-1:0];
    any              = |pick;
    idx              = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) idx = PTR_W'(i);
    end
  end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between NUM_REQ requesters.
// Define ROM_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      rsp_valid,
  output logic [NUM_REQ-1:0]        rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      rsp_ready
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  generate
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("rom_rr_arbiter: NUM_REQ must be within 2..8");
    end
  endgenerate

  rom_arb_state_e     state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] pick_valid;
  logic               grant_any;
  logic               grant_ok;
  logic [ADDR_W-1:0]  grant_addr;
  logic [ADDR_W-1:0]  addr_q;

  // A new request may be taken while idle, or while the current response drains.
  assign grant_ok   = rst_n && ((state == IDLE) || rsp_ready);
  assign pick_valid = req_valid & {NUM_REQ{grant_ok}};

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .valid (pick_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign req_ready = grant;
  assign ptr_next  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // The ROM keeps seeing the last granted address while nobody is granted.
  assign rom_addr = grant_any ? grant_addr : addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rr_ptr    <= '0;
      addr_q    <= '0;
    end else if (grant_any) begin
      state     <= RESP;
      rsp_valid <= 1'b1;
      rsp_id    <= grant;
      rsp_data  <= rom_data;
      rr_ptr    <= ptr_next;
      addr_q    <= grant_addr;
    end else if (state == RESP && rsp_ready) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end
  end

`ifdef ROM_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
      assign grant_cnt[g*16 +: 16] = cnt_q[g];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Self-checking bench for rom_rr_arbiter: vector table, hand-written corner cases, random vs model.
module tb_rom_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic            rsp_valid;
  logic [N-1:0]    rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_ready;
`ifdef ROM_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  int nCompared;
  int nMismatched;

  rom_rr_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
`ifdef ROM_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // ROM model: each word is its address repeated in both nibbles.
  assign rom_data = {rom_addr, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  valid;
    logic          rspReady;
    logic [N-1:0]  expReady;
    logic          expVld;
    logic [N-1:0]  expId;
    logic [DW-1:0] expData;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic rdy);
    req_valid = valid;
    rsp_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Behavioural model state for the random phase.
  int            mPtr;
  bit            mVld;
  logic [N-1:0]  mId;
  logic [DW-1:0] mData;
  logic          curValid [N];
  logic [AW-1:0] curAddr  [N];
  logic [N-1:0]  prevGrant;

  initial begin
    int            gi;
    logic [N-1:0]  expRdy;
    logic [AW-1:0] ga;

    nCompared   = 0;
    nMismatched = 0;

    // Reset with every requester asking.
    rst_n    = 1'b0;
    req_addr = {4'h4, 4'h3, 4'h2, 4'h1};
    applyStimulus(4'b1111, 1'b1);
    tick();
    tick();
    checkOutput("reset_req_ready", 64'(req_ready), 64'h0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("reset_rsp_data",  64'(rsp_data),  64'h0);
    checkOutput("reset_rsp_id",    64'(rsp_id),    64'h0);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("first_grant_ready", 64'(req_ready), 64'b0001);
    tick();
    checkOutput("first_grant_vld",  64'(rsp_valid), 64'h1);
    checkOutput("first_grant_id",   64'(rsp_id),    64'b0001);
    checkOutput("first_grant_data", 64'(rsp_data),  64'h11);

    // Vector table: requester i sits at address i+1 throughout.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'h11};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'h33};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'h44};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'h11};
    vecs[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'h33};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 8'h33};
    vecs[7]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'h11};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001, 8'h11};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'h22};
    vecs[10] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'h44};
    vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1000, 8'h44};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1000, 8'h44};

    applyStimulus(4'b0000, 1'b1);
    doReset();
    tick();
    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v].valid, vecs[v].rspReady);
      #1;
      checkOutput($sformatf("vec%0d_req_ready", v), 64'(req_ready), 64'(vecs[v].expReady));
      tick();
      checkOutput($sformatf("vec%0d_rsp_valid", v), 64'(rsp_valid), 64'(vecs[v].expVld));
      if (vecs[v].expVld) begin
        checkOutput($sformatf("vec%0d_rsp_id", v),   64'(rsp_id),   64'(vecs[v].expId));
        checkOutput($sformatf("vec%0d_rsp_data", v), 64'(rsp_data), 64'(vecs[v].expData));
      end
    end
    checkOutput("rom_addr_hold", 64'(rom_addr), 64'h4);

    // Backpressure while holding an 8'hAA response.
    req_addr = {4'hA, 4'h3, 4'h2, 4'h1};
    applyStimulus(4'b1000, 1'b1);
    #1;
    checkOutput("bp_grant", 64'(req_ready), 64'b1000);
    tick();
    checkOutput("bp_data_first", 64'(rsp_data), 64'hAA);
    applyStimulus(4'b1111, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("bp_stall%0d_ready", c), 64'(req_ready), 64'h0);
      tick();
      checkOutput($sformatf("bp_stall%0d_vld", c),  64'(rsp_valid), 64'h1);
      checkOutput($sformatf("bp_stall%0d_data", c), 64'(rsp_data),  64'hAA);
      checkOutput($sformatf("bp_stall%0d_id", c),   64'(rsp_id),    64'b1000);
    end
    checkOutput("bp_rom_addr_hold", 64'(rom_addr), 64'hA);
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_resume_ready", 64'(req_ready), 64'b0001);
    tick();
    checkOutput("bp_resume_data", 64'(rsp_data), 64'h11);
    checkOutput("bp_resume_id",   64'(rsp_id),   64'b0001);

    // Async reset between edges while a response is live (rr_ptr is 1 here).
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_rsp_valid", 64'(rsp_valid), 64'h0);
    checkOutput("areset_rsp_data",  64'(rsp_data),  64'h0);
    checkOutput("areset_req_ready", 64'(req_ready), 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("areset_ptr_zero", 64'(req_ready), 64'b0001);

`ifdef ROM_ARB_STATS_EN
    applyStimulus(4'b0000, 1'b1);
    doReset();
    tick();
    applyStimulus(4'b0010, 1'b1);
    for (int c = 0; c < 5; c++) tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("stats_cnt1", 64'(grant_cnt[31:16]), 64'd5);
    checkOutput("stats_cnt0", 64'(grant_cnt[15:0]),  64'd0);
    checkOutput("stats_cnt2", 64'(grant_cnt[47:32]), 64'd0);
    checkOutput("stats_cnt3", 64'(grant_cnt[63:48]), 64'd0);
    applyStimulus(4'b0001, 1'b1);
    for (int c = 0; c < 65540; c++) tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("stats_saturate", 64'(grant_cnt[15:0]), 64'hFFFF);
    checkOutput("stats_cnt1_kept", 64'(grant_cnt[31:16]), 64'd5);
`endif

    // Random traffic against a round-robin model.
    applyStimulus(4'b0000, 1'b1);
    doReset();
    tick();
    mPtr      = 0;
    mVld      = 1'b0;
    mId       = '0;
    mData     = '0;
    prevGrant = '0;
    for (int i = 0; i < N; i++) begin
      curValid[i] = 1'b0;
      curAddr[i]  = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!(curValid[i] && !prevGrant[i]) || $urandom_range(0, 3) == 0) begin
          curValid[i] = 1'($urandom_range(0, 1));
          curAddr[i]  = 4'($urandom);
        end
        req_valid[i]          = curValid[i];
        req_addr[i*AW +: AW]  = curAddr[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      gi = -1;
      if (!mVld || rsp_ready) begin
        for (int k = 0; k < N; k++) begin
          if (gi < 0 && curValid[(mPtr + k) % N]) gi = (mPtr + k) % N;
        end
      end
      expRdy = (gi >= 0) ? N'(1 << gi) : '0;
      checkOutput("rand_req_ready", 64'(req_ready), 64'(expRdy));
      if (gi >= 0) begin
        ga = curAddr[gi];
        checkOutput("rand_rom_addr", 64'(rom_addr), 64'(ga));
      end
      tick();
      if (gi >= 0) begin
        mVld  = 1'b1;
        mId   = expRdy;
        mData = {ga, ga};
        mPtr  = (gi + 1) % N;
      end else if (mVld && rsp_ready) begin
        mVld = 1'b0;
      end
      checkOutput("rand_rsp_valid", 64'(rsp_valid), 64'(mVld));
      if (mVld) begin
        checkOutput("rand_rsp_id",   64'(rsp_id),   64'(mId));
        checkOutput("rand_rsp_data", 64'(rsp_data), 64'(mData));
      end
      prevGrant = expRdy;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
